// File: rtl/neuron_lut_loader.sv
// Reloadable LogicNets neuron: truth table loaded over a valid/ready stream and
// read with one-cycle registered latency.
module neuron_lut_loader #(
  parameter int unsigned IN_BITS  = 8,
  parameter int unsigned OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [OUT_BITS-1:0] cfg_data,
  input  logic                cfg_last,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  M0,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] M1,
  output logic                loaded,
  output logic                err_len
);

  localparam int unsigned ENTRIES = 2 ** IN_BITS;
  localparam logic [IN_BITS-1:0] LastAddr = '1;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

  state_e               state_q, state_d, eff_state;
  logic [IN_BITS-1:0]   addr_q, addr_d, eff_addr;
  logic                 loaded_q, loaded_d;
  logic                 err_q, err_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0]  m1_q, m1_d;
  logic                 beat;
  logic                 we;
  logic [IN_BITS-1:0]   waddr;

  // Not reset: loaded_q gates every read, so stale contents never escape.
  logic [OUT_BITS-1:0]  table_q [ENTRIES];

  assign cfg_ready = (state_q != StIdle);
  assign beat      = cfg_valid && cfg_ready;

  // A start pulse makes the beat in the same cycle the first beat of a new load.
  assign eff_state = cfg_start ? StLoad : state_q;
  assign eff_addr  = cfg_start ? '0 : addr_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    we       = 1'b0;
    waddr    = eff_addr;

    if (cfg_start) begin
      state_d  = StLoad;
      addr_d   = '0;
      loaded_d = 1'b0;
      err_d    = 1'b0;
    end

    if (beat) begin
      case (eff_state)
        StLoad: begin
          we     = 1'b1;
          addr_d = eff_addr + IN_BITS'(1);
          if (cfg_last) begin
            state_d = StIdle;
            if (eff_addr == LastAddr) begin
              loaded_d = 1'b1;
            end else begin
              loaded_d = 1'b0;
              err_d    = 1'b1;
            end
          end else if (eff_addr == LastAddr) begin
            state_d = StDrain;
            err_d   = 1'b1;
          end
        end
        StDrain: begin
          if (cfg_last) begin
            state_d  = StIdle;
            loaded_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_valid_d = in_valid && (state_q == StIdle);
    m1_d        = (out_valid_d && loaded_q) ? table_q[M0] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      loaded_q    <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      m1_q        <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      loaded_q    <= loaded_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      m1_q        <= m1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      table_q[waddr] <= cfg_data;
    end
  end

  assign out_valid = out_valid_q;
  assign M1        = m1_q;
  assign loaded    = loaded_q;
  assign err_len   = err_q;

endmodule

// File: tb/tb_neuron_lut_loader.sv
// Randomized scoreboard bench for neuron_lut_loader: loads are judged per stream
// by beat count, lookups are checked by a decoupled monitor against a table model.
module tb_neuron_lut_loader;

  localparam int ENTRIES = 256;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       cfg_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_data  = '0;
  logic       cfg_last  = 1'b0;
  logic       in_valid  = 1'b0;
  logic [7:0] M0        = '0;
  logic       cfg_ready;
  logic       out_valid;
  logic [1:0] M1;
  logic       loaded;
  logic       err_len;

  neuron_lut_loader #(
    .IN_BITS (8),
    .OUT_BITS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_data (cfg_data),
    .cfg_last (cfg_last),
    .in_valid (in_valid),
    .M0       (M0),
    .out_valid(out_valid),
    .M1       (M1),
    .loaded   (loaded),
    .err_len  (err_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] addr;
    logic [1:0] val;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [1:0] mtbl[ENTRIES];
  bit         mloaded = 1'b0;
  bit         merr    = 1'b0;
  logic [1:0] beats[$];
  logic [1:0] src[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every expected lookup must appear exactly on its due cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL lookup_missing: addr %0h got none expected %0h", mon_e.addr, mon_e.val);
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL lookup_valid: addr %0h got out_valid=%b expected 1", mon_e.addr,
                 out_valid);
      end else if (M1 !== mon_e.val) begin
        errors++;
        $display("FAIL lookup_data: addr %0h got %0h expected %0h", mon_e.addr, M1,
                 mon_e.val);
      end
    end else if (out_valid === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL lookup_unexpected: got out_valid=1 M1=%0h expected out_valid=0", M1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A load is judged only by how many beats it carried before cfg_last.
  task automatic finish_load();
    int nb = beats.size();
    for (int i = 0; i < nb && i < ENTRIES; i++) mtbl[i] = beats[i];
    mloaded = (nb == ENTRIES);
    merr    = (nb != ENTRIES);
    beats.delete();
  endtask

  task automatic lookup_exp(input logic [7:0] a, input logic [1:0] v);
    exp_t e;
    in_valid = 1'b1;
    M0       = a;
    e.due    = cyc + 1;
    e.addr   = a;
    e.val    = v;
    exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic lookups(input int n, input bit all_addr);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = all_addr ? 8'(i) : 8'($urandom);
      lookup_exp(a, mloaded ? mtbl[a] : 2'b00);
      if (!all_addr && $urandom_range(3) == 0) tick();
    end
  endtask

  task automatic stream(input int n, input int last_idx, input int gap_pct,
                        input int restart_at, input int reset_at);
    in_valid  = 1'b0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    beats.delete();
    mloaded = 1'b0;
    merr    = 1'b0;
    for (int k = 0; k < n; k++) begin
      while ($urandom_range(99) < gap_pct) begin
        cfg_valid = 1'b0;
        in_valid  = 1'($urandom_range(1));
        M0        = 8'($urandom);
        tick();
        check("cfg_ready_gap", cfg_ready, 1);
      end
      if (k == reset_at) begin
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        rst       = 1'b0;
        tick();
        rst = 1'b1;
        mloaded = 1'b0;
        merr    = 1'b0;
        beats.delete();
        check("abort_loaded", loaded, 0);
        check("abort_err_len", err_len, 0);
        check("abort_cfg_ready", cfg_ready, 0);
        return;
      end
      check("cfg_ready_beat", cfg_ready, 1);
      cfg_start = (k == restart_at);
      if (cfg_start) beats.delete();
      cfg_valid = 1'b1;
      cfg_data  = src[k];
      cfg_last  = (k == last_idx);
      in_valid  = 1'($urandom_range(1));
      M0        = 8'($urandom);
      tick();
      beats.push_back(src[k]);
      cfg_start = 1'b0;
      if (cfg_last) break;
      if (beats.size() == ENTRIES) check("drain_err_len", err_len, 1);
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    in_valid  = 1'b0;
    finish_load();
    check("load_loaded", loaded, 32'(mloaded));
    check("load_err_len", err_len, 32'(merr));
    check("load_cfg_ready", cfg_ready, 0);
  endtask

  task automatic fill_src(input int n, input bit counting);
    src.delete();
    for (int k = 0; k < n; k++) src.push_back(counting ? 2'(k) : 2'($urandom));
  endtask

  initial begin
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    check("rst_loaded", loaded, 0);
    check("rst_err_len", err_len, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_M1", M1, 0);
    lookup_exp(8'h5A, 2'b00);

    fill_src(ENTRIES, 1'b1);
    stream(ENTRIES, ENTRIES - 1, 0, -1, -1);
    lookup_exp(8'h07, 2'b11);
    lookup_exp(8'h04, 2'b00);
    lookups(ENTRIES, 1'b1);
    lookups(64, 1'b0);

    // Overwrite with random data, then reload the counting pattern with gaps.
    fill_src(ENTRIES, 1'b0);
    stream(ENTRIES, ENTRIES - 1, 0, -1, -1);
    fill_src(ENTRIES, 1'b1);
    stream(ENTRIES, ENTRIES - 1, 30, -1, -1);
    lookups(ENTRIES, 1'b1);

    fill_src(ENTRIES, 1'b0);
    stream(ENTRIES, 100, 10, -1, -1);
    lookups(32, 1'b0);

    fill_src(300, 1'b0);
    stream(300, 299, 0, -1, -1);
    lookups(32, 1'b0);

    fill_src(ENTRIES, 1'b0);
    stream(ENTRIES, ENTRIES - 1, 0, -1, 50);
    lookups(8, 1'b0);
    fill_src(ENTRIES, 1'b0);
    stream(ENTRIES, ENTRIES - 1, 0, -1, -1);
    lookups(ENTRIES, 1'b1);

    fill_src(30 + ENTRIES, 1'b0);
    stream(30 + ENTRIES, 30 + ENTRIES - 1, 0, 30, -1);
    lookups(ENTRIES, 1'b1);
    lookups(64, 1'b0);

    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_lut_loader.md
# neuron_lut_loader

Runtime-programmable LogicNets neuron: holds an `ENTRIES x OUT_BITS` truth table in distributed RAM, loaded over a valid/ready configuration stream, and answers lookups with one-cycle registered latency. It is the write side of the fixed-ROM neuron tables emitted by the generator. The same `M0`/`M1` lookup contract lets layer wrappers swap a ROM neuron for a reloadable one during HGCAL autoencoder bring-up.

## Interface
- `IN_BITS`, 8, lookup address width (fan-in × input bit-width)
- `OUT_BITS`, 2, table entry width
- `ENTRIES`, 2**IN_BITS, table depth; derived, not overridden
- `clk`  input  1  single clock, all logic rising-edge
- `rst`  input  1  synchronous, active-low reset
- `cfg_start`  input  1  pulse: begin a new table load at address 0
- `cfg_valid`  input  1  config beat valid
- `cfg_ready`  output  1  config beat accepted when `cfg_valid && cfg_ready`
- `cfg_data`  input  OUT_BITS  table entry for the current address
- `cfg_last`  input  1  marks final beat of a load
- `in_valid`  input  1  lookup request
- `M0`  input  IN_BITS  lookup address
- `out_valid`  output  1  `M1` valid
- `M1`  output  OUT_BITS  looked-up entry, registered
- `loaded`  output  1  table holds a complete, length-checked image
- `err_len`  output  1  sticky: last load had the wrong beat count

## Operation
- States: IDLE, LOAD, DRAIN.
- IDLE:
  - `cfg_ready=0`.
  - `cfg_start` → LOAD, `addr=0`, `loaded=0`, `err_len=0`.
- LOAD:
  - `cfg_ready=1`.
  - Each accepted beat writes `cfg_data` to `table[addr]` and increments `addr`.
  - Accepted beat with `addr==ENTRIES-1 && cfg_last` → IDLE, `loaded=1`.
  - Accepted beat with `cfg_last && addr<ENTRIES-1` → IDLE, `err_len=1`, `loaded=0`.
  - Accepted beat with `addr==ENTRIES-1 && !cfg_last` → DRAIN, `err_len=1`.
- DRAIN:
  - `cfg_ready=1`, no table writes.
  - Accepted beat with `cfg_last` → IDLE, `loaded=0`.
- `cfg_start` in LOAD or DRAIN restarts the load: `addr=0`, `err_len=0`, state LOAD. A beat accepted in the same cycle as `cfg_start` is written to address 0.
- Addressing is linear: entry k of the stream goes to `table[k]`, and `M0==k` reads it.
- Lookup:
  - In IDLE, `in_valid` produces `out_valid=1` on the next cycle.
  - `M1 = loaded ? table[M0] : 0`.
  - In LOAD or DRAIN, `in_valid` is ignored (`out_valid=0`, `M1=0`).
- The table storage is not reset. Only `loaded` gates output, so an unloaded table never leaks stale contents.

## Timing
- Reset (`rst=0` sampled at an edge): state IDLE, `addr=0`, `cfg_ready=0`, `out_valid=0`, `M1=0`, `loaded=0`, `err_len=0`.
- Reset during LOAD or DRAIN aborts the load; `loaded=0` afterwards.
- `cfg_ready` is a registered state decode and goes high the cycle after `cfg_start`.
- A full load takes ENTRIES accepted beats; with `cfg_valid` held high that is 256 cycles after `cfg_ready` rises.
- `loaded` rises the cycle after the final beat is accepted.
- The first valid lookup is the request presented in the cycle `loaded` is first 1; its result appears on the next cycle.
- Lookup latency is 1 cycle. Throughput is 1 lookup/cycle in IDLE.
- The write port is synchronous; the read is asynchronous into the output register.
- No read-during-write hazard exists, because lookups are blocked in LOAD.

## Test plan
- Reset, then `in_valid=1`, `M0=8'h5A` → `out_valid=1`, `M1=2'b00`, `loaded=0`, `err_len=0`.
- `cfg_start`, then 256 beats with `cfg_data=k[1:0]` and `cfg_last` on beat 255 → `loaded=1`; lookup `M0=8'h07` returns `2'b11`, `M0=8'h04` returns `2'b00`; back-to-back lookups at 1/cycle.
- Load with random `cfg_valid` gaps → same table contents as the gap-free load; `cfg_ready` stays 1 throughout LOAD.
- `cfg_last` on beat 100 → IDLE, `err_len=1`, `loaded=0`; lookups return 0.
- 300 beats with `cfg_last` on beat 299 → DRAIN entered after beat 255, `err_len=1`, `loaded=0`; table entries 0..255 unchanged by beats 256–299.
- `rst=0` mid-load at beat 50, then a full reload → `loaded=1` and the new contents read back; `cfg_start` at beat 30 of a load restarts at address 0, verified by readback.
